// File: rtl/seg_pkg.sv
// Shared types, segment font and round-robin digit picker for the seg_scan_ctrl scanner.
// Pure declarations: no latency, no flow control.
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low segments, gfedcba order, indexed by hex value
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Returns {found, index} of the first set mask bit after cur, wrapping back to cur last.
   function automatic logic [2:0] rr_pick(input logic [1:0] cur, input logic [3:0] mask);
      logic [2:0] pick;
      logic [1:0] cand;
      pick = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         cand = cur + 2'(k);
         if (mask[cand]) pick = {1'b1, cand};
      end
      return pick;
   endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Combinational, zero latency; no flow control.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner: BLANK gap, then SHOW dwell per enabled digit.
// Moore outputs; load accepted only in BLANK (load_ready low during SHOW). SEG_SCAN_DIM_EN adds brightness PWM.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int TIMEBITS = 3,
   parameter int BLANKCYC = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   input  logic [3:0]  digit_en,
`ifdef SEG_SCAN_DIM_EN
   input  logic [1:0]  brightness,
`endif
   output logic [3:0]  enables,
   output logic [6:0]  seg
);

   localparam int CW = (TIMEBITS > 4) ? TIMEBITS : 4;
   localparam int LW = CW + 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'((1 << TIMEBITS) - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANKCYC - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   shadow;
   logic [2:0]    pick;
   logic          blank_done;
   logic          show_done;
   logic          enter_show;
   logic          lit;
   logic [3:0]    digit;
   logic [6:0]    dec_seg;

   assign pick       = rr_pick(idx, digit_en);
   assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
   assign show_done  = (state == SHOW) && (cnt == SHOW_LAST);
   assign enter_show = blank_done && pick[2];
   assign load_ready = (state == BLANK) && !reset;

   always_ff @(posedge clk) begin
      if (reset) state <= BLANK;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BLANK:   if (enter_show) state_nxt = SHOW;
         SHOW:    if (show_done)  state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase
   end

   // Shadow only moves in BLANK, so a digit never changes mid-dwell
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         idx    <= 2'd3;
         shadow <= 16'h0000;
      end else begin
         if (blank_done || show_done) cnt <= '0;
         else                         cnt <= cnt + CW'(1);
         if (enter_show) idx <= pick[1:0];
         if (load_valid && load_ready) shadow <= load_data;
      end
   end

`ifdef SEG_SCAN_DIM_EN
   logic [1:0]    bright;
   logic [LW-1:0] lit_len;

   always_ff @(posedge clk) begin
      if (reset)           bright <= 2'd0;
      else if (enter_show) bright <= brightness;
   end

   assign lit_len = LW'({1'b0, bright} + 3'd1) << (TIMEBITS - 2);
   assign lit     = ({1'b0, cnt} < lit_len);
`else
   assign lit = 1'b1;
`endif

   assign digit = shadow[{idx, 2'b00} +: 4];

   seg_decode u_dec (
      .hex (digit),
      .seg (dec_seg)
   );

   always_comb begin
      enables = 4'b0000;
      seg     = SEG_BLANK;
      if ((state == SHOW) && lit) begin
         enables = 4'b0001 << idx;
         seg     = dec_seg;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (TIMEBITS=3, BLANKCYC=1) against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

   localparam int TBITS = 3;
   localparam int BC    = 1;
   localparam int D     = 1 << TBITS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] load_data = 16'h0000;
   logic [3:0]  digit_en = 4'b0000;
   logic [3:0]  enables;
   logic [6:0]  seg;
`ifdef SEG_SCAN_DIM_EN
   logic [1:0]  brightness = 2'd3;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   int          c = 0;
   logic [15:0] m_shadow = 16'h0000;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.TIMEBITS(TBITS), .BLANKCYC(BC)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .digit_en   (digit_en),
`ifdef SEG_SCAN_DIM_EN
      .brightness (brightness),
`endif
      .enables    (enables),
      .seg        (seg)
   );

   function automatic logic [6:0] ref_font(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s at model cycle %0d: observed=%h expected=%h", tag, c, obs, exp);
      end
   endtask

   // Enabled digits repeat in ascending order; each slot is BC blank cycles then D show cycles.
   task automatic expect_now(output logic [3:0] e_en, output logic [6:0] e_seg, output logic e_rdy);
      int lst[4];
      int n, p, slot, w, on_len;
      n = 0;
      for (int i = 0; i < 4; i++) if (digit_en[i]) begin lst[n] = i; n++; end
      e_en  = 4'b0000;
      e_seg = 7'b1111111;
      e_rdy = 1'b1;
      if (n != 0) begin
         p    = c % (n * (BC + D));
         slot = p / (BC + D);
         w    = p % (BC + D);
         if (w >= BC) begin
            e_rdy  = 1'b0;
            on_len = D;
`ifdef SEG_SCAN_DIM_EN
            on_len = (int'(brightness) + 1) * D / 4;
`endif
            if (w - BC < on_len) begin
               e_en  = 4'(1 << lst[slot]);
               e_seg = ref_font(m_shadow[lst[slot]*4 +: 4]);
            end
         end
      end
      if (reset) e_rdy = 1'b0;
   endtask

   // mode 0: no load after this cycle, 1: random loads, 2: hold current offer until accepted
   task automatic step(input int mode);
      logic [3:0] e_en;
      logic [6:0] e_seg;
      logic       e_rdy;
      logic       took;
      @(negedge clk);
      expect_now(e_en, e_seg, e_rdy);
      chk("enables", 16'(enables), 16'(e_en));
      chk("seg", 16'(seg), 16'(e_seg));
      chk("load_ready", 16'(load_ready), 16'(e_rdy));
      took = e_rdy && load_valid;
      if (took) m_shadow = load_data;
      c++;
      @(posedge clk);
      #1;
      case (mode)
         0: load_valid = 1'b0;
         1: begin
            load_valid = ($urandom_range(0, 5) == 0);
            load_data  = 16'($urandom);
         end
         default: if (took) load_valid = 1'b0;
      endcase
   endtask

   task automatic do_reset(input logic [3:0] mask);
      reset      = 1'b1;
      load_valid = 1'b0;
      digit_en   = mask;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      c        = 0;
      m_shadow = 16'h0000;
   endtask

   task automatic load_first(input logic [15:0] d);
      load_valid = 1'b1;
      load_data  = d;
      step(0);
   endtask

   initial begin
      // Reset state while reset is held
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_enables", 16'(enables), 16'h0000);
      chk("rst_seg", 16'(seg), 16'h007F);
      chk("rst_load_ready", 16'(load_ready), 16'h0000);
      @(posedge clk);
      #1;

      // All four digits, 12EF, three full rotations
      do_reset(4'b1111);
      load_first(16'h12EF);
      repeat (3 * 4 * (BC + D)) step(0);

      // Digits 0 and 2 only
      do_reset(4'b0101);
      load_first(16'h5A3C);
      repeat (3 * 2 * (BC + D)) step(0);

      // No digits enabled: permanently blank and always ready
      do_reset(4'b0000);
      repeat (30) step(1);

      // Offer AAAA on the 3rd SHOW cycle and hold until accepted
      do_reset(4'b1111);
      load_first(16'h12EF);
      step(0);
      step(0);
      load_valid = 1'b1;
      load_data  = 16'hAAAA;
      repeat (3 * (BC + D)) step(2);
      load_valid = 1'b0;

      // Reset during the 5th SHOW cycle with a concurrent load offer
      do_reset(4'b1111);
      load_first(16'h12EF);
      repeat (4) step(0);
      reset      = 1'b1;
      load_valid = 1'b1;
      load_data  = 16'hBEEF;
      step(0);
      reset    = 1'b0;
      c        = 0;
      m_shadow = 16'h0000;
      repeat (2 * (BC + D)) step(0);

`ifdef SEG_SCAN_DIM_EN
      brightness = 2'd1;
      do_reset(4'b1111);
      load_first(16'h8421);
      repeat (2 * 4 * (BC + D)) step(0);
`endif

      // Random masks, data and load traffic
      for (int s = 0; s < 8; s++) begin
`ifdef SEG_SCAN_DIM_EN
         brightness = 2'($urandom_range(0, 3));
`endif
         do_reset(4'($urandom_range(0, 15)));
         load_first(16'($urandom));
         repeat (70) step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
